// File: rtl/mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arb
// Description : Packet-level round-robin arbiter. It merges N valid/ready
//               request streams into one downstream stream. The winner keeps
//               the grant until its beat flagged 'last' is accepted, so
//               multi-beat packets are never interleaved. Each output beat is
//               tagged with the index of the requester that sent it.
//
// Parameters  : WIDTH - payload bits per beat
//               N     - number of requesters (2..8)
//               IBITS - requester index width, equal to clog2(N)
//
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req_data[N*W]   - payloads; requester i at [i*WIDTH +: WIDTH]
//               req_last[N]     - last-beat flag per requester
//               req_valid[N]    - valid per requester
//               req_ready[N]    - ready per requester (at most one bit set)
//               out_data/out_last/out_id/out_valid - downstream beat
//               out_ready       - downstream ready
//               busy            - high while a packet is locked
//
// Build option: MEM_REQ_ARB_OUTPUT_REG_EN - when defined, a two-entry skid
//               buffer registers the output path (1-cycle latency, full
//               throughput, req_ready independent of out_ready). When
//               undefined the mux path is purely combinational.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arb #(
    parameter int WIDTH = 64,
    parameter int N     = 2,
    parameter int IBITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [IBITS-1:0]   out_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IBITS-1:0] r_gnt;
    logic [IBITS-1:0] w_gnt_nxt;
    logic [IBITS-1:0] r_last_gnt;
    logic [IBITS-1:0] w_last_gnt_nxt;

    logic [IBITS-1:0] w_pick;
    logic [IBITS-1:0] w_sel;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;
    logic             w_mux_valid;
    logic             w_in_ready;   // arbiter side may hand over a beat
    logic             w_acc;        // beat accepted by the arbiter this cycle

    // ------------------------------------------------------------------------
    // Round-robin pick: first valid requester searching upward from
    // last_gnt+1 (mod N). The loop runs from the farthest offset to the
    // nearest so the nearest valid requester overwrites the others. With
    // nothing valid the pick rests on last_gnt+1, which is 0 after reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick = IBITS'((int'(r_last_gnt) + 1) % N);
        for (int k = N; k >= 1; k--) begin
            if (req_valid[(int'(r_last_gnt) + k) % N]) begin
                w_pick = IBITS'((int'(r_last_gnt) + k) % N);
            end
        end
    end

    assign w_sel = (r_state == ST_LOCK) ? r_gnt : w_pick;

    // Input mux following the selected requester.
    always_comb begin
        w_mux_data  = '0;
        w_mux_last  = 1'b0;
        w_mux_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == IBITS'(i)) begin
                w_mux_data  = req_data[i*WIDTH +: WIDTH];
                w_mux_last  = req_last[i];
                w_mux_valid = req_valid[i];
            end
        end
    end

    // Only the selected requester ever sees ready.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = (w_sel == IBITS'(i)) && w_in_ready;
        end
    end

    assign w_acc = w_mux_valid && w_in_ready;
    assign busy  = (r_state == ST_LOCK);

    // ------------------------------------------------------------------------
    // Packet lock FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_last_gnt <= IBITS'(N - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_mux_last) begin
                        // Single-beat packet: never locks, but rotates priority.
                        w_last_gnt_nxt = w_sel;
                    end else begin
                        w_state_nxt = ST_LOCK;
                        w_gnt_nxt   = w_sel;
                    end
                end
            end
            ST_LOCK: begin
                if (w_acc && w_mux_last) begin
                    w_state_nxt    = ST_IDLE;
                    w_last_gnt_nxt = r_gnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_REQ_ARB_OUTPUT_REG_EN
    // ------------------------------------------------------------------------
    // Two-entry skid buffer: a head register drives the outputs directly and
    // a skid register catches the beat accepted while the head is stalled.
    // Ready toward the arbiter is simply "not full", so it never depends on
    // out_ready combinationally.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_hd_data;
    logic             r_hd_last;
    logic [IBITS-1:0] r_hd_id;
    logic             r_hd_vld;
    logic [WIDTH-1:0] r_sk_data;
    logic             r_sk_last;
    logic [IBITS-1:0] r_sk_id;
    logic             r_sk_vld;
    logic             w_pop;

    assign w_in_ready = !(r_hd_vld && r_sk_vld);
    assign w_pop      = r_hd_vld && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd_data <= '0;
            r_hd_last <= 1'b0;
            r_hd_id   <= '0;
            r_hd_vld  <= 1'b0;
            r_sk_data <= '0;
            r_sk_last <= 1'b0;
            r_sk_id   <= '0;
            r_sk_vld  <= 1'b0;
        end else if (w_pop || !r_hd_vld) begin
            // Head slot frees up: refill from skid first to keep order.
            if (r_sk_vld) begin
                r_hd_data <= r_sk_data;
                r_hd_last <= r_sk_last;
                r_hd_id   <= r_sk_id;
                r_hd_vld  <= 1'b1;
                if (w_acc) begin
                    r_sk_data <= w_mux_data;
                    r_sk_last <= w_mux_last;
                    r_sk_id   <= w_sel;
                end
                r_sk_vld <= w_acc;
            end else if (w_acc) begin
                r_hd_data <= w_mux_data;
                r_hd_last <= w_mux_last;
                r_hd_id   <= w_sel;
                r_hd_vld  <= 1'b1;
            end else begin
                r_hd_vld <= 1'b0;
            end
        end else if (w_acc) begin
            // Head stalled; the skid is necessarily empty here (ready = !full).
            r_sk_data <= w_mux_data;
            r_sk_last <= w_mux_last;
            r_sk_id   <= w_sel;
            r_sk_vld  <= 1'b1;
        end
    end

    assign out_data  = r_hd_data;
    assign out_last  = r_hd_last;
    assign out_id    = r_hd_id;
    assign out_valid = r_hd_vld;
`else
    assign w_in_ready = out_ready;
    assign out_data   = w_mux_data;
    assign out_last   = w_mux_last;
    assign out_id     = w_sel;
    assign out_valid  = w_mux_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arb
// Description : Self-checking bench for mem_req_arb (N=2). Directed cycle
//               table and hand-written sequences for the combinational build,
//               then randomized traffic against a transaction-level reference
//               model (round-robin rule plus an output queue for the
//               registered build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arb;

    localparam int WIDTH = 64;
    localparam int N     = 2;
    localparam int IBITS = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_last;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [IBITS-1:0]   out_id;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_arb #(.WIDTH(WIDTH), .N(N), .IBITS(IBITS)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_last(req_last), .req_valid(req_valid),
        .req_ready(req_ready),
        .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: packet-level round robin written from the rules.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        int               id;
    } beat_t;

    bit    m_lock;
    int    m_owner;
    int    m_last;
    beat_t m_q[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return (last + 1) % N;
    endfunction

    // ------------------------------------------------------------------------
    // Directed cycle table (combinational build)
    // ------------------------------------------------------------------------
    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         ordy;
        logic         e_valid;
        logic [IBITS-1:0] e_id;
        logic         e_last;
        logic [N-1:0] e_ready;
        logic         e_busy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int    sel;
        bit    acc;
        beat_t hb;
        logic [7:0] got[$];
        int    sent;

        do_reset();

        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);

`ifndef MEM_REQ_ARB_OUTPUT_REG_EN
        //          v      l      ordy ev  id    el    erdy   eb
        tbl[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        // both always valid, single-beat packets: 0,1,0,1
        tbl[1]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[2]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[3]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[4]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0};
        // 4-beat packet from requester 0 while requester 1 stays valid
        tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[6]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[8]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
        tbl[9]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0};
        // requester 0 locks, then drops valid for 3 cycles
        tbl[10] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[11] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[12] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[13] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[14] = '{2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
        tbl[15] = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0};

        for (int r = 0; r < 16; r++) begin
            logic [WIDTH-1:0] d0, d1;
            d0 = 64'hA000 + 64'(r);
            d1 = 64'hB000 + 64'(r);
            req_valid = tbl[r].v;
            req_last  = tbl[r].l;
            req_data  = {d1, d0};
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("tbl%0d_valid", r), 64'(out_valid), 64'(tbl[r].e_valid));
            chk($sformatf("tbl%0d_id", r), 64'(out_id), 64'(tbl[r].e_id));
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].e_ready));
            chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
            if (tbl[r].e_valid) begin
                chk($sformatf("tbl%0d_last", r), 64'(out_last), 64'(tbl[r].e_last));
                chk($sformatf("tbl%0d_data", r), out_data, tbl[r].e_id ? d1 : d0);
            end
            @(negedge clk);
        end

        // out_ready toggling while requester 0 streams 0x10..0x13
        sent = 0;
        for (int c = 0; c < 12 && sent < 4; c++) begin
            req_valid = 2'b01;
            req_last  = (sent == 3) ? 2'b01 : 2'b00;
            req_data  = {64'hDEAD, 64'(8'h10 + sent)};
            out_ready = (c % 2 == 0);
            #1;
            chk("tog_ready", 64'(req_ready), 64'({1'b0, out_ready}));
            if (out_valid && out_ready) begin
                got.push_back(out_data[7:0]);
                sent++;
            end
            @(negedge clk);
        end
        chk("tog_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tog_beat%0d", i),
                (i < got.size()) ? 64'(got[i]) : 64'hFF, 64'(8'h10 + i));
        end

        // Reset in the middle of a requester-1 packet
        req_valid = 2'b10; req_last = 2'b00; req_data = '0; out_ready = 1'b1;
        #1;
        chk("rmid_id", 64'(out_id), 64'd1);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rmid_busy_before", 64'(busy), 64'd1);
        chk("rmid_owner", 64'(out_id), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmid_busy_after", 64'(busy), 64'd0);
        chk("rmid_winner", 64'(out_id), 64'd0);
        @(negedge clk);
`endif

        // --------------------------------------------------------------------
        // Randomized traffic against the reference model
        // --------------------------------------------------------------------
        do_reset();
        m_lock = 0; m_owner = 0; m_last = N - 1;
        m_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] e_ready;
            req_valid = N'($urandom);
            req_last  = N'($urandom_range(0, 2) == 0 ? $urandom : 0);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            sel = m_lock ? m_owner : rr_pick(req_valid, m_last);
            chk("rnd_busy", 64'(busy), 64'(m_lock));
`ifdef MEM_REQ_ARB_OUTPUT_REG_EN
            e_ready = '0;
            e_ready[sel] = (m_q.size() < 2);
            acc = req_valid[sel] && (m_q.size() < 2);
            chk("rnd_valid", 64'(out_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                hb = m_q[0];
                chk("rnd_id", 64'(out_id), 64'(hb.id));
                chk("rnd_data", out_data, hb.data);
                chk("rnd_last", 64'(out_last), 64'(hb.last));
                if (out_ready) void'(m_q.pop_front());
            end
            if (acc) begin
                hb.data = req_data[sel*WIDTH +: WIDTH];
                hb.last = req_last[sel];
                hb.id   = sel;
                m_q.push_back(hb);
            end
`else
            e_ready = '0;
            e_ready[sel] = out_ready;
            acc = req_valid[sel] && out_ready;
            chk("rnd_valid", 64'(out_valid), 64'(req_valid[sel]));
            chk("rnd_id", 64'(out_id), 64'(sel));
            if (req_valid[sel]) begin
                chk("rnd_data", out_data, req_data[sel*WIDTH +: WIDTH]);
                chk("rnd_last", 64'(out_last), 64'(req_last[sel]));
            end
`endif
            chk("rnd_ready", 64'(req_ready), 64'(e_ready));
            // Model state update for the coming clock edge.
            if (acc) begin
                if (!m_lock) begin
                    if (req_last[sel]) m_last = sel;
                    else begin m_lock = 1; m_owner = sel; end
                end else if (req_last[sel]) begin
                    m_lock = 0; m_last = m_owner;
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
